load_store_unit: RTL and testbench

Sits between the execute stage and `data_memory`. Turns byte-addressed load/store requests into word accesses on the memory's single read/write port. Supports byte, halfword and word sizes with sign or zero extension. Sub-word stores use a read-modify-write sequence. Every request gets exactly one response through a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/load_store_unit_if.sv | 27 ++
 rtl/lsu_align.sv | 40 ++++
 rtl/load_store_unit.sv | 136 +++++++++++++
 tb/tb_load_store_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LANE_W     = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } lsu_size_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4,
    RESP  = 3'd5
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle between the execute stage and the LSU.
interface load_store_unit_if;
  import lsu_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  lsu_size_t        req_size;
  logic             req_signed;
  logic [XLEN-1:0]  req_addr;
  logic [XLEN-1:0]  req_wdata;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_rdata;
  logic             resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_align.sv
// Lane arithmetic: load extraction/extension and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0]   i_word,
  input  logic [LANE_W-1:0] i_lane,
  input  lsu_size_t         i_size,
  input  logic              i_signed,
  input  logic [XLEN-1:0]   i_wdata,
  output logic [XLEN-1:0]   o_load,
  output logic [XLEN-1:0]   o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_lane, 3'b000} +: 8];
  assign w_half = i_word[{i_lane[1], 4'b0000} +: 16];

  always_comb begin
    o_load   = '0;
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_load = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load = {{16{i_signed & w_half[15]}}, w_half};
        o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      SZ_WORD: begin
        o_load   = i_word;
        o_merged = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a single-port word memory.
// Errors are answered straight from ERR; sub-word stores read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wd,
  input  logic [XLEN-1:0]  mem_rd
);

  lsu_state_t        r_state, w_state_nxt;
  logic              r_req_ready, w_req_ready_nxt;
  logic              r_resp_valid, w_resp_valid_nxt;
  logic              r_resp_err, w_resp_err_nxt;
  logic [XLEN-1:0]   r_resp_rdata, w_resp_rdata_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [XLEN-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [XLEN-1:0]   r_word, w_word_nxt;
  lsu_size_t         r_size;
  logic [LANE_W-1:0] r_lane;
  logic              r_signed;

  logic              w_accept;
  logic              w_err;
  logic [XLEN-1:0]   w_idx;
  logic [XLEN-1:0]   w_load;
  logic [XLEN-1:0]   w_merged;

  assign w_accept = bus.req_valid && r_req_ready;
  assign w_idx    = XLEN'(bus.req_addr[XLEN-1:LANE_W]);
  assign w_err    = (bus.req_size == SZ_ILL)
                 || (bus.req_size == SZ_HALF && bus.req_addr[0])
                 || (bus.req_size == SZ_WORD && bus.req_addr[LANE_W-1:0] != '0)
                 || (w_idx >= XLEN'(DEPTH));

  lsu_align u_align (
    .i_word   (mem_rd),
    .i_lane   (r_lane),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_wdata  (r_word),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and next values of every registered output
  always_comb begin
    w_state_nxt      = r_state;
    w_mem_addr_nxt   = r_mem_addr;
    w_word_nxt       = r_word;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
    case (r_state)
      IDLE: if (w_accept) begin
        w_mem_addr_nxt   = w_idx;
        w_word_nxt       = bus.req_wdata;
        w_resp_rdata_nxt = '0;
        w_resp_err_nxt   = w_err;
        if (w_err)                       w_state_nxt = ERR;
        else if (!bus.req_write)         w_state_nxt = LOAD;
        else if (bus.req_size == SZ_WORD) w_state_nxt = WRITE;
        else                             w_state_nxt = MERGE;
      end
      LOAD: begin
        w_resp_rdata_nxt = w_load;
        w_state_nxt      = RESP;
      end
      MERGE: begin
        w_word_nxt  = w_merged;
        w_state_nxt = WRITE;
      end
      WRITE: w_state_nxt = RESP;
      ERR:   w_state_nxt = bus.resp_ready ? IDLE : RESP;
      RESP:  if (bus.resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt == IDLE) begin
      w_mem_addr_nxt   = '0;
      w_resp_rdata_nxt = '0;
      w_resp_err_nxt   = 1'b0;
    end
    w_req_ready_nxt  = (w_state_nxt == IDLE);
    w_mem_we_nxt     = (w_state_nxt == WRITE);
    w_resp_valid_nxt = (w_state_nxt == RESP) || (w_state_nxt == ERR);
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_word       <= '0;
      r_size       <= SZ_BYTE;
      r_lane       <= '0;
      r_signed     <= 1'b0;
    end else begin
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_word       <= w_word_nxt;
      if (w_accept) begin
        r_size   <= bus.req_size;
        r_lane   <= bus.req_addr[LANE_W-1:0];
        r_signed <= bus.req_signed;
      end
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_wd         = r_word;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random checks of load_store_unit against a byte-array model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_init;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [31:0] mem [DEPTH];
  logic [7:0]  rb  [DEPTH*4];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  assign mem_rd = mem[mem_addr[AW-1:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i);
    end else if (mem_we) begin
      mem[mem_addr[AW-1:0]] <= mem_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int idx);
    return {rb[4*idx+3], rb[4*idx+2], rb[4*idx+1], rb[4*idx]};
  endfunction

  task automatic issue(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input int hold);
    int          nb, idx, exp_lat, lat, we_cnt, we_lat, waits;
    bit          e;
    logic [31:0] exp_rd, we_addr, we_wd, exp_word;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e   = (sz == 2'd3) || ((a % 32'(nb)) != 0) || ((a >> 2) >= 32'(DEPTH));
    idx = int'(a >> 2);
    exp_rd = '0;
    if (!e && !w) begin
      for (int k = 0; k < nb; k++) exp_rd |= 32'(rb[int'(a) + k]) << (8 * k);
      if (sg && nb < 4 && exp_rd[8*nb-1]) exp_rd |= ~((32'd1 << (8 * nb)) - 32'd1);
    end
    exp_lat = e ? 1 : (!w ? 2 : (nb == 4 ? 2 : 3));

    @(negedge clk);
    waits = 0;
    while (!bus.req_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = lsu_size_t'(sz);
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;

    lat = 0; we_cnt = 0; we_lat = 0; we_addr = '0; we_wd = '0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (mem_we) begin
        we_cnt++; we_lat = lat; we_addr = mem_addr; we_wd = mem_wd;
      end
      if (bus.resp_valid) break;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rdata"}, bus.resp_rdata, exp_rd);
    chk({tag, " err"}, 32'(bus.resp_err), 32'(e));
    chk({tag, " busy"}, 32'(bus.req_ready), 32'd0);

    if (w && !e) begin
      for (int k = 0; k < nb; k++) rb[int'(a) + k] = wd[8*k +: 8];
      exp_word = model_word(idx);
      chk({tag, " we_cnt"}, 32'(we_cnt), 32'd1);
      chk({tag, " we_cycle"}, 32'(we_lat), 32'(exp_lat - 1));
      chk({tag, " we_addr"}, we_addr, 32'(idx));
      chk({tag, " we_data"}, we_wd, exp_word);
    end else begin
      chk({tag, " no_we"}, 32'(we_cnt), 32'd0);
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, 32'(bus.resp_valid), 32'd1);
      chk({tag, " hold rdata"}, bus.resp_rdata, exp_rd);
      chk({tag, " hold err"}, 32'(bus.resp_err), 32'(e));
      chk({tag, " hold busy"}, 32'(bus.req_ready), 32'd0);
      chk({tag, " hold we"}, 32'(mem_we), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, " idle ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, " idle valid"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    logic [1:0]  rsz;
    logic [31:0] ra;
    int          r;

    rst = 1'b1; mem_init = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = SZ_BYTE;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    for (int i = 0; i < DEPTH * 4; i++) rb[i] = ((i % 4) == 0) ? 8'(i / 4) : 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;

    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wd", mem_wd, 32'd0);

    issue("ld_w_14", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0);
    issue("st_b_09", 1'b1, 2'd0, 1'b0, 32'h09, 32'h0000_00AB, 0);
    chk("st_b_09 memword", mem[2], 32'h0000_AB02);
    issue("ld_bs_09", 1'b0, 2'd0, 1'b1, 32'h09, 32'h0, 0);
    issue("ld_bu_09", 1'b0, 2'd0, 1'b0, 32'h09, 32'h0, 0);
    issue("st_h_0e", 1'b1, 2'd1, 1'b0, 32'h0E, 32'h1234_8001, 0);
    issue("ld_hs_0e", 1'b0, 2'd1, 1'b1, 32'h0E, 32'h0, 0);
    issue("ld_w_0c", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 0);
    issue("err_h_03", 1'b0, 2'd1, 1'b0, 32'h03, 32'h0, 0);
    issue("err_st_82", 1'b1, 2'd2, 1'b0, 32'h82, 32'hDEAD_BEEF, 0);
    issue("err_ld_80", 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 0);
    issue("err_ill", 1'b1, 2'd3, 1'b0, 32'h04, 32'h55, 1);
    issue("bp_ld", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 3);

    // Reset while a sub-word store sits in MERGE
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = SZ_BYTE;
    bus.req_signed = 1'b0; bus.req_addr = 32'h11; bus.req_wdata = 32'h77;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst req_ready", 32'(bus.req_ready), 32'd1);
    chk("mrst resp_rdata", bus.resp_rdata, 32'd0);
    chk("mrst resp_err", 32'(bus.resp_err), 32'd0);
    chk("mrst mem_addr", mem_addr, 32'd0);
    chk("mrst mem_wd", mem_wd, 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk("mrst mem_we", 32'(mem_we), 32'd0);
      chk("mrst resp_valid", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end
    chk("mrst memword", mem[4], model_word(4));

    for (int n = 0; n < 60; n++) begin
      r   = int'($urandom_range(0, 9));
      rsz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      ra  = 32'($urandom_range(0, DEPTH * 4 + 15));
      if ($urandom_range(0, 3) != 0) ra = ra & ~((rsz == 2'd1) ? 32'd1 : 32'd3);
      issue($sformatf("rnd%0d", n), 1'($urandom), rsz, 1'($urandom), ra, $urandom,
            int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < DEPTH; i++) chk($sformatf("final mem%0d", i), mem[i], model_word(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
